// File: rtl/mu_error_gen_if.sv
// mu_error_gen_if: sample/handshake bundle for mu_error_gen.
//   master: drives desired sample d_n/d_valid, filter output y_n/y_valid,
//           step size mu and adapt_en; observes error, mu_error,
//           mu_error_valid and the sticky status flags.
//   slave : the error generator side of the same signals.
// All data fields are signed fixed point carried as WIDTH-bit vectors.
interface mu_error_gen_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] d_n;
  logic             d_valid;
  logic [WIDTH-1:0] y_n;
  logic             y_valid;
  logic [WIDTH-1:0] mu;
  logic             adapt_en;
  logic [WIDTH-1:0] error;
  logic [WIDTH-1:0] mu_error;
  logic             mu_error_valid;
  logic             sat_flag;
  logic             ovf_flag;
  logic             unf_flag;

  modport master (
    output d_n, d_valid, y_n, y_valid, mu, adapt_en,
    input  error, mu_error, mu_error_valid, sat_flag, ovf_flag, unf_flag
  );

  modport slave (
    input  d_n, d_valid, y_n, y_valid, mu, adapt_en,
    output error, mu_error, mu_error_valid, sat_flag, ovf_flag, unf_flag
  );
endinterface

// File: rtl/mu_error_gen.sv
// mu_error_gen: LMS error generator.
// Aligns each desired sample d[n] (buffered in a DEPTH-entry FIFO) with the
// later-arriving filter output y[n], forms error = sat(d - y) in stage 1 and
// mu_error = sat(round(mu * error) >> QP) in stage 2.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high, overrides everything
//   bus   - mu_error_gen_if.slave: d_n/d_valid, y_n/y_valid, mu, adapt_en in;
//           error, mu_error, mu_error_valid, sat_flag, ovf_flag, unf_flag out
module mu_error_gen #(
  parameter int WIDTH = 16,
  parameter int QP    = 12,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  mu_error_gen_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] RND =
    {{(2*WIDTH-1){1'b0}}, 1'b1} << (QP-1);

  // alignment FIFO
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop_ok;
  logic             push_ok;
  logic [WIDTH-1:0] d_pop;

  // pipeline state
  logic             s1_valid;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] mu_q;
  logic [WIDTH-1:0] mu_err_q;
  logic             mu_err_valid_q;
  logic             sat_q;
  logic             ovf_q;
  logic             unf_q;

  // stage-1 arithmetic
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        err_sat;
  logic                    clamp1;

  // stage-2 arithmetic
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] rnd;
  logic signed [2*WIDTH-1:0] shf;
  logic [WIDTH:0]            shf_hi;
  logic [WIDTH-1:0]          mu_sat;
  logic                      clamp2;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  // No bypass: a pop needs a stored entry; a push at full is accepted only
  // when a same-cycle pop frees the slot (wr_ptr == rd_ptr in that case, the
  // read below sees the old word before the write lands).
  assign pop_ok     = bus.y_valid && !fifo_empty;
  assign push_ok    = bus.d_valid && (!fifo_full || pop_ok);
  assign d_pop      = fifo_mem[rd_ptr];

  always_comb begin
    diff    = {d_pop[WIDTH-1], d_pop} - {bus.y_n[WIDTH-1], bus.y_n};
    clamp1  = (diff[WIDTH] != diff[WIDTH-1]);
    err_sat = diff[WIDTH-1:0];
    if (clamp1) err_sat = diff[WIDTH] ? SMIN : SMAX;
  end

  always_comb begin
    prod   = $signed(err_q) * $signed(mu_q);
    rnd    = prod + RND;
    shf    = rnd >>> QP;
    shf_hi = shf[2*WIDTH-1:WIDTH-1];
    clamp2 = !((&shf_hi) || (~|shf_hi));
    mu_sat = shf[WIDTH-1:0];
    if (clamp2) mu_sat = shf[2*WIDTH-1] ? SMIN : SMAX;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.d_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (bus.d_valid && !push_ok) ovf_q <= 1'b1;
      if (bus.y_valid && fifo_empty && !bus.d_valid) unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      err_q          <= '0;
      mu_q           <= '0;
      mu_err_q       <= '0;
      mu_err_valid_q <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      s1_valid <= pop_ok;
      if (pop_ok) begin
        err_q <= err_sat;
        mu_q  <= bus.mu;
        if (clamp1) sat_q <= 1'b1;
      end
      mu_err_valid_q <= s1_valid;
      if (s1_valid) begin
        if (bus.adapt_en) begin
          mu_err_q <= mu_sat;
          if (clamp2) sat_q <= 1'b1;
        end else begin
          mu_err_q <= '0;
        end
      end
    end
  end

  assign bus.error          = err_q;
  assign bus.mu_error       = mu_err_q;
  assign bus.mu_error_valid = mu_err_valid_q;
  assign bus.sat_flag       = sat_q;
  assign bus.ovf_flag       = ovf_q;
  assign bus.unf_flag       = unf_q;

endmodule

// File: tb/tb_mu_error_gen.sv
// tb_mu_error_gen: scoreboard bench for mu_error_gen (WIDTH=16, QP=12, DEPTH=8).
module tb_mu_error_gen;

  logic clk;
  logic reset;

  mu_error_gen_if #(.WIDTH(16)) bus ();

  mu_error_gen #(.WIDTH(16), .QP(12), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] err;
    logic [15:0] mu;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mq[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          aen      = 1'b1;
  bit          exp_sat, exp_ovf, exp_unf;
  logic [15:0] exp_err, exp_mu;
  logic [15:0] err_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
  endtask

  function automatic logic [15:0] sat16(input longint v, output bit clamped);
    clamped = 1'b0;
    if (v > 32767)  begin clamped = 1'b1; return 16'h7fff; end
    if (v < -32768) begin clamped = 1'b1; return 16'h8000; end
    return v[15:0];
  endfunction

  task automatic step(input bit rst, input bit dv, input logic [15:0] d,
                      input bit yv, input logic [15:0] y, input logic [15:0] m);
    bit     pop_ok, push_ok, c1, c2;
    longint diff, p;
    exp_t   e;
    logic [15:0] dp;
    reset        = rst;
    bus.d_valid  = dv;
    bus.d_n      = d;
    bus.y_valid  = yv;
    bus.y_n      = y;
    bus.mu       = m;
    bus.adapt_en = aen;
    if (rst) begin
      mq.delete(); sb.delete();
      exp_sat = 0; exp_ovf = 0; exp_unf = 0; exp_err = '0; exp_mu = '0;
    end else begin
      pop_ok  = yv && (mq.size() > 0);
      push_ok = dv && ((mq.size() < 8) || pop_ok);
      if (dv && !push_ok) exp_ovf = 1;
      if (yv && mq.size() == 0 && !dv) exp_unf = 1;
      if (pop_ok) begin
        dp    = mq.pop_front();
        diff  = longint'($signed(dp)) - longint'($signed(y));
        e.err = sat16(diff, c1);
        p     = longint'($signed(e.err)) * longint'($signed(m)) + 2048;
        e.mu  = sat16(p >>> 12, c2);
        if (!aen) begin e.mu = '0; c2 = 0; end
        if (c1 || c2) exp_sat = 1;
        exp_err = e.err;
        exp_mu  = e.mu;
        sb.push_back(e);
      end
      if (push_ok) mq.push_back(d);
    end
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.d_valid = 1'b0;
    bus.y_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0);
  endtask

  task automatic checkpoint(input string name);
    @(negedge clk);
    check({name, ".error"},    bus.error,          exp_err);
    check({name, ".mu_error"}, bus.mu_error,       exp_mu);
    check({name, ".valid"},    bus.mu_error_valid, 0);
    check({name, ".sat"},      bus.sat_flag,       exp_sat);
    check({name, ".ovf"},      bus.ovf_flag,       exp_ovf);
    check({name, ".unf"},      bus.unf_flag,       exp_unf);
    @(posedge clk); #1;
  endtask

  // Stage-1 value of a sample is on error one cycle before its strobe.
  always @(negedge clk) begin
    if (bus.mu_error_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb.mu_error", bus.mu_error, e.mu);
        check("sb.error",    err_prev,     e.err);
      end
    end
    err_prev = bus.error;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv, rm;
    bus.d_valid = 0; bus.y_valid = 0; bus.d_n = '0; bus.y_n = '0;
    bus.mu = '0; bus.adapt_en = 1; reset = 1;
    #1;
    step(1, 0, '0, 0, '0, '0);
    step(1, 0, '0, 0, '0, '0);
    checkpoint("reset");

    // basic pairing and negative rounding
    step(0, 1, 16'd2048, 0, '0, '0);
    idle(1);
    step(0, 0, '0, 1, 16'd1024, 16'd410);
    idle(3);
    checkpoint("basic");
    step(0, 1, 16'd0, 0, '0, '0);
    step(0, 0, '0, 1, 16'd1024, 16'd410);
    idle(3);
    checkpoint("neg_round");

    // stage-1 saturation
    step(0, 1, 16'h7fff, 0, '0, '0);
    step(0, 0, '0, 1, 16'h8000, 16'd4096);
    idle(3);
    checkpoint("sat1");

    // stage-2 saturation only
    step(1, 0, '0, 0, '0, '0);
    step(0, 1, 16'd16384, 0, '0, '0);
    step(0, 0, '0, 1, 16'd0, 16'd8192);
    idle(3);
    checkpoint("sat2");

    // overflow, drain in order, underflow
    step(1, 0, '0, 0, '0, '0);
    for (int i = 0; i < 9; i++) begin
      rv = 16'($urandom);
      step(0, 1, rv, 0, '0, '0);
    end
    checkpoint("ovf");
    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom);
      rm = 16'($urandom_range(0, 8191) - 4096);
      step(0, 0, '0, 1, rv, rm);
    end
    idle(3);
    checkpoint("drain");
    step(0, 0, '0, 1, 16'd5, 16'd100);
    idle(3);
    checkpoint("unf");

    // full-rate streaming at count == DEPTH
    step(1, 0, '0, 0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom_range(0, 16383));
      step(0, 1, rv, 0, '0, '0);
    end
    for (int i = 0; i < 20; i++) begin
      rv = 16'($urandom_range(0, 16383));
      rm = 16'($urandom_range(0, 16383));
      step(0, 1, rv, 1, rm, 16'($urandom_range(0, 4095)));
    end
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 16'd100, 16'd300);
    idle(3);
    checkpoint("stream");

    // freeze
    aen = 1'b0;
    idle(1);
    step(0, 1, 16'd3000, 0, '0, '0);
    step(0, 0, '0, 1, 16'd1000, 16'd2000);
    idle(3);
    checkpoint("freeze");
    aen = 1'b1;

    // reset while stage 1 holds a valid sample
    step(0, 1, 16'd2000, 0, '0, '0);
    step(0, 0, '0, 1, 16'd100, 16'd500);
    step(1, 0, '0, 0, '0, '0);
    idle(2);
    checkpoint("mid_reset");

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
